act_quant_pipe: RTL and testbench

//  Parametrised post-MAC activation + requantisation stage: LANES signed accumulator results in, LANES

---
 rtl/act_quant_pipe_pkg.sv | 28 ++
 rtl/act_quant_lane.sv | 79 +++++++
 rtl/act_quant_pipe.sv | 98 +++++++++
 tb/tb_act_quant_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_quant_pipe_pkg.sv
// Shared encodings, default widths and shift-amount helpers for the activation/requantisation pipe.
package act_quant_pipe_pkg;

  typedef enum logic [1:0] {
    ACT_MODE_BYPASS = 2'd0,
    ACT_MODE_RELU   = 2'd1,
    ACT_MODE_LEAKY  = 2'd2,
    ACT_MODE_CLIP   = 2'd3
  } act_mode_e;

  localparam int DEF_LANES       = 8;
  localparam int DEF_MAC_W       = 32;
  localparam int DEF_FEA_W       = 16;
  localparam int DEF_LEAKY_SHIFT = 3;
  localparam int DEF_SAT_CNT_W   = 16;

  // qs spans -15..30; left shifts need at most 16 extra bits of headroom.
  localparam int QS_W        = 6;
  localparam int QS_MIN      = -15;
  localparam int QS_MAX      = 30;
  localparam int QS_HEADROOM = 16;

  function automatic logic signed [QS_W-1:0] calc_qs(input logic [3:0] fi, input logic [3:0] w,
                                                     input logic [3:0] fo);
    return $signed({2'b00, fi}) + $signed({2'b00, w}) - $signed({2'b00, fo});
  endfunction

endpackage

// File: rtl/act_quant_lane.sv
// One lane: activation register (S1), then round/shift/saturate/clip into the output register (S2).
module act_quant_lane
  import act_quant_pipe_pkg::*;
#(
  parameter int MW          = DEF_MAC_W,
  parameter int FW          = DEF_FEA_W,
  parameter int LEAKY_SHIFT = DEF_LEAKY_SHIFT
) (
  input  logic                   system_clk,
  input  logic                   rst_n,
  input  logic                   ld1_i,
  input  logic                   ld2_i,
  input  act_mode_e              mode_i,
  input  logic signed [QS_W-1:0] qs_i,
  input  logic        [FW-1:0]   clip_max_i,
  input  logic signed [MW-1:0]   x_i,
  output logic signed [FW-1:0]   y_o,
  output logic                   sat_o
);

  localparam int EW = MW + QS_HEADROOM;
  localparam logic signed [EW-1:0] RND_ONE = EW'(1);
  localparam logic signed [EW-1:0] SMAX = {{(EW-FW+1){1'b0}}, {(FW-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-FW+1){1'b1}}, {(FW-1){1'b0}}};

  logic signed [MW-1:0]   act_d, act_q;
  logic signed [EW-1:0]   ext, shd;
  logic        [QS_W-1:0] qs_neg;
  logic        [4:0]      sh_r, sh_l;
  logic signed [FW-1:0]   sat_val, y_d;
  logic                   sat_d;

  always_comb begin
    act_d = x_i;
    unique case (mode_i)
      ACT_MODE_RELU, ACT_MODE_CLIP: act_d = x_i[MW-1] ? '0 : x_i;
      ACT_MODE_LEAKY:               act_d = x_i[MW-1] ? (x_i >>> LEAKY_SHIFT) : x_i;
      default:                      act_d = x_i;
    endcase
  end

  // Shift in a widened domain so neither the rounding add nor a left shift can overflow.
  always_comb begin
    qs_neg = -qs_i;
    sh_r   = qs_i[4:0];
    sh_l   = qs_neg[4:0];
    ext    = {{QS_HEADROOM{act_q[MW-1]}}, act_q};
    shd    = ext;
    if (qs_i > 0)      shd = (ext + (RND_ONE << (sh_r - 5'd1))) >>> sh_r;
    else if (qs_i < 0) shd = ext <<< sh_l;

    sat_d   = 1'b0;
    sat_val = shd[FW-1:0];
    if (shd > SMAX) begin
      sat_val = SMAX[FW-1:0];
      sat_d   = 1'b1;
    end else if (shd < SMIN) begin
      sat_val = SMIN[FW-1:0];
      sat_d   = 1'b1;
    end

    y_d = sat_val;
    if (mode_i == ACT_MODE_CLIP && $signed({sat_val[FW-1], sat_val}) > $signed({1'b0, clip_max_i}))
      y_d = clip_max_i;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      y_o   <= '0;
    end else begin
      if (ld1_i) act_q <= act_d;
      if (ld2_i) y_o   <= y_d;
    end
  end

  assign sat_o = sat_d;

endmodule

// File: rtl/act_quant_pipe.sv
// Two-stage activation + requantisation pipe with valid/ready backpressure and saturation statistics.
module act_quant_pipe
  import act_quant_pipe_pkg::*;
#(
  parameter int LANES            = DEF_LANES,
  parameter int MAC_OUTPUT_WIDTH = DEF_MAC_W,
  parameter int FEATURE_WIDTH    = DEF_FEA_W,
  parameter int LEAKY_SHIFT      = DEF_LEAKY_SHIFT,
  parameter int SAT_CNT_WIDTH    = DEF_SAT_CNT_W
) (
  input  logic                                system_clk,
  input  logic                                rst_n,
  input  logic [1:0]                          act_mode,
  input  logic [FEATURE_WIDTH-1:0]            clip_max,
  input  logic [3:0]                          fea_in_quant_size,
  input  logic [3:0]                          weight_quant_size,
  input  logic [3:0]                          fea_out_quant_size,
  input  logic                                stat_clear,
  input  logic [LANES*MAC_OUTPUT_WIDTH-1:0]   in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [LANES*FEATURE_WIDTH-1:0]      out_data,
  output logic                                out_valid,
  output logic                                out_last,
  input  logic                                out_ready,
  output logic                                busy,
  output logic [SAT_CNT_WIDTH-1:0]            sat_count
);

  localparam int PW = $clog2(LANES + 1);

  logic [2:1]               vld_pipe_q, vld_pipe_d, last_q, last_d;
  logic                     s2_free, s1_adv, ld1;
  logic signed [QS_W-1:0]   qs;
  logic [LANES-1:0]         sat_vec;
  logic [PW-1:0]            pop;
  logic [SAT_CNT_WIDTH:0]   sat_sum;
  logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  assign qs       = calc_qs(fea_in_quant_size, weight_quant_size, fea_out_quant_size);
  assign s2_free  = !vld_pipe_q[2] || out_ready;
  assign s1_adv   = vld_pipe_q[1] && s2_free;
  assign in_ready = !vld_pipe_q[1] || s2_free;
  assign ld1      = in_valid && in_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_quant_lane #(
      .MW(MAC_OUTPUT_WIDTH), .FW(FEATURE_WIDTH), .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .system_clk (system_clk),
      .rst_n      (rst_n),
      .ld1_i      (ld1),
      .ld2_i      (s1_adv),
      .mode_i     (act_mode_e'(act_mode)),
      .qs_i       (qs),
      .clip_max_i (clip_max),
      .x_i        (in_data[g*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH]),
      .y_o        (out_data[g*FEATURE_WIDTH +: FEATURE_WIDTH]),
      .sat_o      (sat_vec[g])
    );
  end

  always_comb begin
    vld_pipe_d[1] = ld1 || (vld_pipe_q[1] && !s1_adv);
    vld_pipe_d[2] = s1_adv || (vld_pipe_q[2] && !out_ready);
    last_d[1]     = ld1 ? in_last : last_q[1];
    last_d[2]     = s1_adv ? last_q[1] : last_q[2];
  end

  // Counter sticks at all-ones; a clear coinciding with an S2 load drops that load's events.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(sat_vec[i]);
    sat_sum     = {1'b0, sat_count_q} + (SAT_CNT_WIDTH+1)'(pop);
    sat_count_d = sat_count_q;
    if (stat_clear)  sat_count_d = '0;
    else if (s1_adv) sat_count_d = sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_q      <= '0;
      sat_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      last_q      <= last_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_last  = vld_pipe_q[2] && last_q[2];
  assign busy      = |vld_pipe_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_act_quant_pipe.sv
// Scoreboard bench for act_quant_pipe: directed beats push expectations, a negedge monitor checks outputs.
module tb_act_quant_pipe;

  localparam int LANES = 8;
  localparam int MW    = 32;
  localparam int FW    = 16;

  logic                  system_clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            act_mode;
  logic [FW-1:0]         clip_max;
  logic [3:0]            fea_in_quant_size, weight_quant_size, fea_out_quant_size;
  logic                  stat_clear;
  logic [LANES*MW-1:0]   in_data;
  logic                  in_valid, in_last, in_ready;
  logic [LANES*FW-1:0]   out_data;
  logic                  out_valid, out_last, out_ready, busy;
  logic [15:0]           sat_count;

  typedef int vec_t [LANES];
  typedef struct {
    vec_t d;
    bit   last;
    bit   chk_lat;
    int   exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, n_out = 0;
  bit   rand_rdy = 1'b0;
  exp_t mon_e;
  int   mon_bad;
  vec_t xv, ev;

  act_quant_pipe dut (
    .system_clk(system_clk), .rst_n(rst_n), .act_mode(act_mode), .clip_max(clip_max),
    .fea_in_quant_size(fea_in_quant_size), .weight_quant_size(weight_quant_size),
    .fea_out_quant_size(fea_out_quant_size), .stat_clear(stat_clear),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .sat_count(sat_count)
  );

  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) cyc++;

  always @(negedge system_clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: out_valid with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        n_out++;
        mon_bad = -1;
        for (int i = 0; i < LANES; i++)
          if (int'($signed(out_data[i*FW +: FW])) != mon_e.d[i] && mon_bad < 0) mon_bad = i;
        if (mon_bad >= 0) begin
          n_fail++;
          $display("FAIL out_data beat %0d lane %0d: got %0d expected %0d", n_out, mon_bad,
                   $signed(out_data[mon_bad*FW +: FW]), mon_e.d[mon_bad]);
        end
        n_chk++;
        if (out_last !== mon_e.last) begin
          n_fail++;
          $display("FAIL out_last beat %0d: got %0b expected %0b", n_out, out_last, mon_e.last);
        end
        if (mon_e.chk_lat) begin
          n_chk++;
          if (cyc != mon_e.exp_cyc) begin
            n_fail++;
            $display("FAIL latency beat %0d: got cycle %0d expected %0d", n_out, cyc, mon_e.exp_cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] fi, input logic [3:0] w,
                     input logic [3:0] fo, input logic [FW-1:0] clip);
    act_mode = m; fea_in_quant_size = fi; weight_quant_size = w;
    fea_out_quant_size = fo; clip_max = clip;
  endtask

  task automatic send(input vec_t x, input vec_t e, input bit last);
    exp_t en;
    int   n;
    bit   done;
    for (int i = 0; i < LANES; i++) in_data[i*MW +: MW] = x[i];
    in_valid = 1'b1; in_last = last; n = 0; done = 1'b0;
    while (!done) begin
      @(negedge system_clk);
      if (in_ready) begin
        en.d = e; en.last = last; en.chk_lat = !rand_rdy && out_ready; en.exp_cyc = cyc + 2;
        sb.push_back(en);
        done = 1'b1;
      end else if (++n > 500) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"},  int'(out_last), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_in_ready"},  int'(in_ready), 1);
    chk({tag, "_sat_count"}, int'(sat_count), 0);
    n_chk++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL %s_out_data: got %h expected 0", tag, out_data);
    end
  endtask

  initial begin
    int outs0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    stat_clear = 1'b0;
    cfg(2'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    #1;
    chk_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ReLU, qs=0: one lane overflows the feature range
    cfg(2'd1, 4'd0, 4'd0, 4'd0, 16'd0);
    xv = '{-5, 7, 32767, 32768, 0, 1, -1, 100};
    ev = '{0, 7, 32767, 32767, 0, 1, 0, 100};
    send(xv, ev, 1'b0); drain();
    chk("sat_relu", int'(sat_count), 1);

    // leaky ReLU, qs=2 with round half up
    cfg(2'd2, 4'd4, 4'd2, 4'd4, 16'd0);
    xv = '{-64, 6, 0, -1, 10, -32, 1, 2};
    ev = '{-2, 2, 0, 0, 3, -1, 0, 1};
    send(xv, ev, 1'b0); drain();
    chk("sat_leaky", int'(sat_count), 1);

    // bypass, qs=-3 left shift with saturation both ways
    cfg(2'd0, 4'd0, 4'd0, 4'd3, 16'd0);
    xv = '{5000, -5000, 0, 1, -1, 4095, 4096, -4096};
    ev = '{32767, -32768, 0, 8, -8, 32760, 32767, -32768};
    send(xv, ev, 1'b0); drain();
    chk("sat_lshift", int'(sat_count), 4);

    // clipped ReLU at 100, qs=1; only the true overflow lane counts
    cfg(2'd3, 4'd1, 4'd0, 4'd0, 16'd100);
    xv = '{250, -9, 199, 201, 198, 3, 32'h7FFF_FFFF, 1};
    ev = '{100, 0, 100, 100, 99, 2, 100, 1};
    send(xv, ev, 1'b0); drain();
    chk("sat_clip", int'(sat_count), 5);

    // bypass, maximum right shift qs=30 on extreme accumulator values
    cfg(2'd0, 4'd15, 4'd15, 4'd0, 16'd0);
    xv = '{32'h7FFF_FFFF, 32'h8000_0000, 536870912, 536870911, -536870912, -536870913, 0, 1073741824};
    ev = '{2, -2, 1, 0, 0, -1, 0, 1};
    send(xv, ev, 1'b0); drain();
    chk("sat_qs30", int'(sat_count), 5);

    // clear coinciding with the S2 load of a saturating beat wins
    cfg(2'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    xv = '{40000, 0, 0, 0, 0, 0, 0, 0};
    ev = '{32767, 0, 0, 0, 0, 0, 0, 0};
    send(xv, ev, 1'b0);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    drain();
    chk("sat_clear_wins", int'(sat_count), 0);
    send(xv, ev, 1'b0); drain();
    chk("sat_after_clear", int'(sat_count), 1);

    // 16-beat burst under random backpressure, last on the final beat
    outs0 = n_out;
    rand_rdy = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < LANES; i++) xv[i] = b * 1000 - 8000 + i * 37;
      send(xv, xv, b == 15);
    end
    drain();
    rand_rdy = 1'b0; out_ready = 1'b1;
    chk("burst_beats", n_out - outs0, 16);
    chk("burst_sat", int'(sat_count), 1);

    // reset with both stages full
    out_ready = 1'b0;
    xv = '{40000, 1, 2, 3, 4, 5, 6, 7};
    ev = '{32767, 1, 2, 3, 4, 5, 6, 7};
    send(xv, ev, 1'b0);
    send(xv, ev, 1'b1);
    tick();
    chk("full_busy", int'(busy), 1);
    chk("full_in_ready", int'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    cfg(2'd1, 4'd0, 4'd0, 4'd0, 16'd0);
    xv = '{-3, 3, 300, -300, 0, 12345, -1, 1};
    ev = '{0, 3, 300, 0, 0, 12345, 0, 1};
    outs0 = n_out;
    send(xv, ev, 1'b1); drain();
    chk("post_rst_beats", n_out - outs0, 1);
    chk("post_rst_sat", int'(sat_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
